// File: rtl/occ_rx_align_pkg.sv
// Shared types and constants for the OCC RX alignment monitor.
// Holds the supervisor states, the word classes and the GT status codes.
package occ_rx_align_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    REALIGN,
    BLIND,
    HUNT,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    CLS_PAYLOAD,
    CLS_IDLE_OK,
    CLS_IDLE_MISPLACED,
    CLS_BAD_K
  } word_class_t;

  localparam logic [2:0] c_BUFSTATUS_UNDERFLOW = 3'b101;
  localparam logic [2:0] c_BUFSTATUS_OVERFLOW  = 3'b110;
  localparam logic [1:0] c_K_IDLE              = 2'b10;
  localparam logic [1:0] c_K_NONE              = 2'b00;
  localparam logic [1:0] c_K_LOW_BYTE          = 2'b01;

  // Bit 2 flags an elastic-buffer fault; the GT only reports the two named
  // codes, but any other code with bit 2 set is treated the same way.
  function automatic logic is_buf_error(input logic [2:0] status);
    return status inside {c_BUFSTATUS_UNDERFLOW, c_BUFSTATUS_OVERFLOW, 3'b100, 3'b111};
  endfunction

endpackage

// File: rtl/occ_rx_align_monitor_if.sv
// GT RX word stream into the monitor and the aligned payload stream out of it.
// The GT/bench side uses master, the monitor uses slave.
interface occ_rx_align_monitor_if;
  logic [15:0] rx_data_i;
  logic [1:0]  rx_k_i;
  logic [2:0]  rx_bufstatus_i;
  logic        rx_realign_o;
  logic [15:0] rx_data_o;
  logic [1:0]  rx_k_o;
  logic        rx_valid_o;

  modport master (
    output rx_data_i, rx_k_i, rx_bufstatus_i,
    input  rx_realign_o, rx_data_o, rx_k_o, rx_valid_o
  );

  modport slave (
    input  rx_data_i, rx_k_i, rx_bufstatus_i,
    output rx_realign_o, rx_data_o, rx_k_o, rx_valid_o
  );
endinterface

// File: rtl/occ_rx_word_classify.sv
// Classifies the current RX word for the supervisor FSM and registers the
// word itself as the one-cycle-delayed payload datapath.
module occ_rx_word_classify
  import occ_rx_align_pkg::*;
#(
  parameter logic [15:0] g_IDLE = 16'hBC95
) (
  input  logic        usrclk_i,
  input  logic        rst_n_i,
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_k_i,
  output word_class_t word_class,
  output logic [15:0] rx_data_q,
  output logic [1:0]  rx_k_q
);

  // A comma in the low byte with k = 01 is an IDLE landing in the wrong lane.
  always_comb begin
    // NOTE: default assigned first so every path drives word_class; no latch.
    word_class = CLS_BAD_K;
    case (rx_k_i)
      c_K_NONE:     word_class = CLS_PAYLOAD;
      c_K_IDLE:     if (rx_data_i == g_IDLE) word_class = CLS_IDLE_OK;
      c_K_LOW_BYTE: if (rx_data_i[7:0] == g_IDLE[15:8]) word_class = CLS_IDLE_MISPLACED;
      default:      word_class = CLS_BAD_K;
    endcase
  end

  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_q <= '0;
      rx_k_q    <= '0;
    end else begin
      // NOTE: flops take non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      rx_data_q <= rx_data_i;
      rx_k_q    <= rx_k_i;
    end
  end

endmodule

// File: rtl/occ_rx_align_monitor.sv
// GT RX comma alignment supervisor: requests realign, hunts for lane-correct
// IDLEs, declares lock and drops it on timeout, bad K or buffer faults.
module occ_rx_align_monitor
  import occ_rx_align_pkg::*;
#(
  parameter logic [15:0] g_IDLE         = 16'hBC95,
  parameter int unsigned g_REALIGN_LEN  = 8,
  parameter int unsigned g_LOCK_IDLES   = 4,
  parameter int unsigned g_IDLE_TIMEOUT = 1024,
  parameter int unsigned g_BLIND_PERIOD = 10
) (
  input  logic                         usrclk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  occ_rx_align_monitor_if.slave        rx,
  output logic                         aligned_o,
  output logic                         buf_err_o,
  output logic [15:0]                  realign_cnt_o
);

  // Realign and blind phases share one cycle counter; both periods are <= 255.
  localparam logic [7:0]  c_REALIGN_LAST = 8'(g_REALIGN_LEN - 1);
  localparam logic [7:0]  c_BLIND_LAST   = 8'(g_BLIND_PERIOD - 1);
  localparam logic [7:0]  c_LOCK_LAST    = 8'(g_LOCK_IDLES - 1);
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(g_IDLE_TIMEOUT - 1);

  state_t      state, state_nxt;
  word_class_t word_class;
  logic [7:0]  phase_cnt;
  logic [7:0]  lock_cnt;
  logic [15:0] idle_timer;
  logic        realign_q;
  logic        aligned_q;
  logic        valid_q;
  logic        buf_err_q;
  logic [15:0] realign_cnt_q;
  logic [15:0] rx_data_q;
  logic [1:0]  rx_k_q;

  logic idle_ok;
  logic payload;
  logic buf_fault;
  logic timeout;
  logic supervising;
  logic link_fault;

  occ_rx_word_classify #(
    .g_IDLE(g_IDLE)
  ) u_classify (
    .usrclk_i  (usrclk_i),
    .rst_n_i   (rst_n_i),
    .rx_data_i (rx.rx_data_i),
    .rx_k_i    (rx.rx_k_i),
    .word_class(word_class),
    .rx_data_q (rx_data_q),
    .rx_k_q    (rx_k_q)
  );

  assign idle_ok     = (word_class == CLS_IDLE_OK);
  assign payload     = (word_class == CLS_PAYLOAD);
  assign buf_fault   = is_buf_error(rx.rx_bufstatus_i);
  assign timeout     = (idle_timer == c_TIMEOUT_LAST) && !idle_ok;
  assign supervising = (state == HUNT) || (state == LOCKED);
  // All fault sources merge here so simultaneous faults cause one realign.
  assign link_fault  = supervising && (!idle_ok && !payload || buf_fault || timeout);

  always_comb begin
    state_nxt = state;
    case (state)
      DISABLED: if (enable_i) state_nxt = REALIGN;
      REALIGN:  if (phase_cnt == c_REALIGN_LAST) state_nxt = BLIND;
      BLIND:    if (phase_cnt == c_BLIND_LAST) state_nxt = HUNT;
      HUNT: begin
        if (link_fault) begin
          state_nxt = REALIGN;
        end else if (idle_ok && lock_cnt == c_LOCK_LAST) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED:   if (link_fault) state_nxt = REALIGN;
      default:  state_nxt = DISABLED;
    endcase
    if (!enable_i) state_nxt = DISABLED;
  end

  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= DISABLED;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_cnt  <= '0;
      lock_cnt   <= '0;
      idle_timer <= '0;
    end else begin
      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else if (state == REALIGN || state == BLIND) begin
        phase_cnt <= phase_cnt + 8'd1;
      end

      if (state != HUNT) begin
        lock_cnt <= '0;
      end else if (idle_ok) begin
        lock_cnt <= lock_cnt + 8'd1;
      end

      // Held at zero outside HUNT/LOCKED, so it starts from 0 on HUNT entry.
      if (!supervising || idle_ok) begin
        idle_timer <= '0;
      end else begin
        idle_timer <= idle_timer + 16'd1;
      end
    end
  end

  always_ff @(posedge usrclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      realign_q     <= 1'b0;
      aligned_q     <= 1'b0;
      valid_q       <= 1'b0;
      buf_err_q     <= 1'b0;
      realign_cnt_q <= '0;
    end else begin
      realign_q <= (state_nxt == REALIGN);
      aligned_q <= (state_nxt == LOCKED);
      valid_q   <= (state == LOCKED) && payload && !buf_fault && !timeout;

      if (state_nxt == DISABLED) begin
        buf_err_q <= 1'b0;
      end else if (supervising && buf_fault) begin
        buf_err_q <= 1'b1;
      end

      if (state_nxt == REALIGN && state != REALIGN && realign_cnt_q != 16'hFFFF) begin
        realign_cnt_q <= realign_cnt_q + 16'd1;
      end
    end
  end

  assign rx.rx_realign_o = realign_q;
  assign rx.rx_data_o    = rx_data_q;
  assign rx.rx_k_o       = rx_k_q;
  assign rx.rx_valid_o   = valid_q;
  assign aligned_o       = aligned_q;
  assign buf_err_o       = buf_err_q;
  assign realign_cnt_o   = realign_cnt_q;

endmodule

// File: tb/tb_occ_rx_align_monitor.sv
// Scoreboard bench for occ_rx_align_monitor: every driven word queues its
// expected delayed data/k, valid and aligned state, popped after the edge.
module tb_occ_rx_align_monitor;
  import occ_rx_align_pkg::*;

  localparam logic [15:0] IDLE_W    = 16'hBC95;
  localparam logic [15:0] SWAPPED_W = 16'h95BC;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  k;
    logic        valid;
    logic        aligned;
  } exp_t;

  logic        usrclk_i = 1'b0;
  logic        rst_n_i  = 1'b0;
  logic        enable_i = 1'b1;
  logic        aligned_o;
  logic        buf_err_o;
  logic [15:0] realign_cnt_o;

  occ_rx_align_monitor_if rx ();

  occ_rx_align_monitor dut (
    .usrclk_i     (usrclk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .rx           (rx),
    .aligned_o    (aligned_o),
    .buf_err_o    (buf_err_o),
    .realign_cnt_o(realign_cnt_o)
  );

  always #5 usrclk_i = ~usrclk_i;

  exp_t        sb[$];
  int          n_vec     = 0;
  int          n_err     = 0;
  int          exp_rcnt  = 0;
  logic        exp_lock  = 1'b0;
  logic [15:0] wcnt      = 16'h0001;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one word, queue its expectation, compare just after the capturing edge.
  task automatic step(input logic [15:0] d, input logic [1:0] k,
                      input logic [2:0] bs, input logic lock_after);
    exp_t e;
    rx.rx_data_i      = d;
    rx.rx_k_i         = k;
    rx.rx_bufstatus_i = bs;
    e.data    = d;
    e.k       = k;
    e.valid   = exp_lock && lock_after && (k == 2'b00) && !bs[2];
    e.aligned = lock_after;
    sb.push_back(e);
    exp_lock = lock_after;
    @(posedge usrclk_i);
    #1;
    e = sb.pop_front();
    check("rx_data_o",  rx.rx_data_o, e.data);
    check("rx_k_o",     16'(rx.rx_k_o), 16'(e.k));
    check("rx_valid_o", 16'(rx.rx_valid_o), 16'(e.valid));
    check("aligned_o",  16'(aligned_o), 16'(e.aligned));
  endtask

  task automatic payload_word(input logic lock_after);
    step(wcnt, 2'b00, 3'b000, lock_after);
    wcnt++;
  endtask

  // Words first..last; index multiples of period are IDLE, the rest payload.
  task automatic stream(input int first, input int last, input int period, input int lock_idx);
    for (int i = first; i <= last; i++) begin
      if (i % period == 0) step(IDLE_W, 2'b10, 3'b000, exp_lock || (i == lock_idx));
      else                 payload_word(exp_lock);
    end
  endtask

  task automatic apply_reset();
    rst_n_i           = 1'b0;
    exp_lock          = 1'b0;
    exp_rcnt          = 0;
    rx.rx_data_i      = '0;
    rx.rx_k_i         = '0;
    rx.rx_bufstatus_i = '0;
    sb.delete();
    repeat (2) @(posedge usrclk_i);
    #1;
    check("rst rx_realign_o",  16'(rx.rx_realign_o), 16'd0);
    check("rst rx_data_o",     rx.rx_data_o, 16'd0);
    check("rst rx_valid_o",    16'(rx.rx_valid_o), 16'd0);
    check("rst aligned_o",     16'(aligned_o), 16'd0);
    check("rst buf_err_o",     16'(buf_err_o), 16'd0);
    check("rst realign_cnt_o", realign_cnt_o, 16'd0);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    // Reset release, realign pulse length, lock on the 4th in-lane IDLE.
    apply_reset();
    for (int i = 1; i <= 30; i++) begin
      payload_word(1'b0);
      check("realign pulse", 16'(rx.rx_realign_o), 16'((i >= 1 && i <= 8) ? 1 : 0));
    end
    exp_rcnt = 1;
    check("realign_cnt after bring-up", realign_cnt_o, 16'(exp_rcnt));
    stream(31, 772 + 20, 193, 772);
    check("realign_cnt while locked", realign_cnt_o, 16'(exp_rcnt));

    // Byte-swapped stream: every misplaced comma restarts realign.
    apply_reset();
    exp_rcnt = 1;
    for (int i = 1; i <= 600; i++) begin
      if (i % 193 == 0) begin
        step(SWAPPED_W, 2'b01, 3'b000, 1'b0);
        exp_rcnt++;
        check("realign_cnt misplaced comma", realign_cnt_o, 16'(exp_rcnt));
        check("realign on misplaced comma", 16'(rx.rx_realign_o), 16'd1);
      end else begin
        payload_word(1'b0);
      end
    end

    // IDLE starvation on a locked link: lock lost 1024 words after last IDLE.
    apply_reset();
    exp_rcnt = 1;
    stream(1, 128, 32, 128);
    for (int j = 1; j <= 1024; j++) payload_word(j < 1024);
    exp_rcnt++;
    check("timeout realign_o", 16'(rx.rx_realign_o), 16'd1);
    check("timeout realign_cnt", realign_cnt_o, 16'(exp_rcnt));

    // Overflow for one cycle: sticky buf_err_o, drop and relock.
    stream(1, 128, 32, 128);
    step(wcnt, 2'b00, c_BUFSTATUS_OVERFLOW, 1'b0);
    exp_rcnt++;
    check("buf_err set", 16'(buf_err_o), 16'd1);
    check("buf_err realign_cnt", realign_cnt_o, 16'(exp_rcnt));
    stream(1, 128, 32, 128);
    check("buf_err sticky after relock", 16'(buf_err_o), 16'd1);

    // enable_i low forces DISABLED and clears the sticky error.
    enable_i = 1'b0;
    step(IDLE_W, 2'b10, 3'b000, 1'b0);
    step(IDLE_W, 2'b10, 3'b000, 1'b0);
    check("buf_err cleared by disable", 16'(buf_err_o), 16'd0);
    check("realign_o low when disabled", 16'(rx.rx_realign_o), 16'd0);
    enable_i = 1'b1;
    exp_rcnt++;
    stream(1, 128, 32, 128);
    check("realign_cnt after re-enable", realign_cnt_o, 16'(exp_rcnt));

    // Bad K and underflow together: exactly one realign entry.
    step(16'h1234, 2'b11, c_BUFSTATUS_UNDERFLOW, 1'b0);
    exp_rcnt++;
    check("combined fault realign_cnt", realign_cnt_o, 16'(exp_rcnt));
    check("combined fault buf_err", 16'(buf_err_o), 16'd1);
    payload_word(1'b0);
    payload_word(1'b0);
    check("combined fault single increment", realign_cnt_o, 16'(exp_rcnt));
    check("realign_o in pulse cycle 3", 16'(rx.rx_realign_o), 16'd1);

    // Asynchronous reset in the middle of the realign pulse.
    #1;
    rst_n_i = 1'b0;
    #1;
    check("async rst realign_o", 16'(rx.rx_realign_o), 16'd0);
    check("async rst realign_cnt", realign_cnt_o, 16'd0);
    check("async rst buf_err", 16'(buf_err_o), 16'd0);
    check("async rst aligned", 16'(aligned_o), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
